// File: rtl/signed_vector_acc_reader.sv
// signed_vector_acc_reader
// Consumer end of the vector accumulator output stream. Each incoming vector
// of VECTOR_LEN signed beats is captured into one half of a ping-pong buffer.
// The vector is then replayed over a valid/ready handshake together with its
// bin index and a last flag. Each sample is arithmetically shifted right by
// SHIFT and reduced to DOUT_WIDTH bits.
//
// Ports:
//   clk_i, rst_i      - clock, synchronous active-high reset
//   din_i/din_valid_i - signed accumulated sample, strobe (cannot stall)
//   dout_o            - rescaled signed sample (registered)
//   dout_index_o      - bin index of dout_o
//   dout_last_o       - high on index VECTOR_LEN-1
//   dout_valid_o/dout_ready_i - output handshake
//   overflow_o        - sticky: at least one vector was dropped
//   drop_count_o      - dropped vectors, saturating at 0xFFFF
//   sat_flag_o        - sticky clamp indicator (only with the macro below)
//
// Build option: define SIGNED_VECTOR_ACC_READER_SAT_EN to clamp out-of-range
// samples and add sat_flag_o. Otherwise the result wraps (low DOUT_WIDTH bits).
module signed_vector_acc_reader #(
    parameter int DIN_WIDTH  = 64,
    parameter int VECTOR_LEN = 64,
    parameter int DOUT_WIDTH = 32,
    parameter int SHIFT      = 0
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic [DIN_WIDTH-1:0]          din_i,
    input  logic                          din_valid_i,
    output logic [DOUT_WIDTH-1:0]         dout_o,
    output logic [$clog2(VECTOR_LEN)-1:0] dout_index_o,
    output logic                          dout_last_o,
    output logic                          dout_valid_o,
    input  logic                          dout_ready_i,
    output logic                          overflow_o,
    output logic [15:0]                   drop_count_o
`ifdef SIGNED_VECTOR_ACC_READER_SAT_EN
    ,
    output logic                          sat_flag_o
`endif
);

    localparam int IW = $clog2(VECTOR_LEN);
    localparam logic [IW-1:0] LAST_IDX = IW'(VECTOR_LEN - 1);

    // Both banks live in one array; the bank select is the address MSB.
    logic [DIN_WIDTH-1:0] mem_q [2*VECTOR_LEN];
    logic [DIN_WIDTH-1:0] rdata_q;

    // Write side
    logic [IW-1:0] widx_q, widx_d;
    logic          wbank_q, wbank_d;
    logic          wr_act_q, wr_act_d;   // current vector is being stored
    logic [1:0]    full_q, full_d;
    logic          overflow_q, overflow_d;
    logic [15:0]   drop_cnt_q, drop_cnt_d;

    // Read side: ibank/ridx issue BRAM reads, rbank tracks the bank being
    // handed downstream (it lags ibank while the prefetch pipe drains).
    logic          ibank_q, ibank_d;
    logic [IW-1:0] ridx_q, ridx_d;
    logic          rbank_q, rbank_d;
    logic          pend_q, pend_d;       // BRAM read data lands this cycle
    logic [IW-1:0] pend_idx_q, pend_idx_d;
    logic                  skid_v_q, skid_v_d;
    logic [DOUT_WIDTH-1:0] skid_q, skid_d;
    logic [IW-1:0]         skid_idx_q, skid_idx_d;
    logic                  dvalid_q, dvalid_d;
    logic [DOUT_WIDTH-1:0] dout_q, dout_d;
    logic [IW-1:0]         didx_q, didx_d;
    logic                  dlast_q, dlast_d;

    logic release_w, accept0, wr_en, wr_done, drop, pop, rd_en;
    logic [1:0] occ;

    logic signed [DIN_WIDTH-1:0] rd_s;
    logic [DOUT_WIDTH-1:0]       conv;
`ifdef SIGNED_VECTOR_ACC_READER_SAT_EN
    logic [DIN_WIDTH-DOUT_WIDTH:0] rd_hi;
    logic                          rd_clamp;
    logic                          sat_q, sat_d;
`endif

    // Rescale the sample coming out of the BRAM.
    always_comb begin
        rd_s = $signed(rdata_q) >>> SHIFT;
`ifdef SIGNED_VECTOR_ACC_READER_SAT_EN
        // Fits iff every bit from the DOUT sign bit upward is identical.
        rd_hi    = rd_s[DIN_WIDTH-1:DOUT_WIDTH-1];
        rd_clamp = ~((&rd_hi) | ~(|rd_hi));
        if (rd_clamp)
            conv = rd_s[DIN_WIDTH-1] ? {1'b1, {(DOUT_WIDTH-1){1'b0}}}
                                     : {1'b0, {(DOUT_WIDTH-1){1'b1}}};
        else
            conv = rd_s[DOUT_WIDTH-1:0];
`else
        conv = DOUT_WIDTH'(rd_s);
`endif
    end

    always_comb begin
        release_w = dvalid_q & dout_ready_i & dlast_q;
        // A bank released on this very edge may be refilled immediately.
        accept0   = ~full_q[wbank_q] | (release_w & (rbank_q == wbank_q));
        wr_en     = din_valid_i & ((widx_q == '0) ? accept0 : wr_act_q);
        wr_done   = wr_en & (widx_q == LAST_IDX);
        drop      = din_valid_i & (widx_q == '0) & ~accept0;

        pop = dvalid_q & dout_ready_i;
        occ = {1'b0, dvalid_q} + {1'b0, skid_v_q} + {1'b0, pend_q};
        // Two storage slots (output + skid): only issue a read if its data
        // is guaranteed a slot when it lands.
        rd_en = full_q[ibank_q] & ((occ - {1'b0, pop}) <= 2'd1);
    end

    always_comb begin
        widx_d     = din_valid_i ? widx_q + 1'b1 : widx_q;
        wr_act_d   = (din_valid_i && widx_q == '0) ? accept0 : wr_act_q;
        wbank_d    = wr_done ? ~wbank_q : wbank_q;
        overflow_d = overflow_q | drop;
        drop_cnt_d = (drop && drop_cnt_q != 16'hFFFF) ? drop_cnt_q + 16'd1 : drop_cnt_q;
        full_d     = full_q;
        if (release_w) full_d[rbank_q] = 1'b0;
        if (wr_done)   full_d[wbank_q] = 1'b1;

        rbank_d    = release_w ? ~rbank_q : rbank_q;
        ridx_d     = rd_en ? ridx_q + 1'b1 : ridx_q;
        ibank_d    = (rd_en && ridx_q == LAST_IDX) ? ~ibank_q : ibank_q;
        pend_d     = rd_en;
        pend_idx_d = rd_en ? ridx_q : pend_idx_q;

        skid_v_d   = skid_v_q;
        skid_d     = skid_q;
        skid_idx_d = skid_idx_q;
        dvalid_d   = dvalid_q;
        dout_d     = dout_q;
        didx_d     = didx_q;
        dlast_d    = dlast_q;
        if (~dvalid_q | pop) begin
            if (skid_v_q) begin
                dvalid_d = 1'b1;
                dout_d   = skid_q;
                didx_d   = skid_idx_q;
                dlast_d  = (skid_idx_q == LAST_IDX);
                skid_v_d = pend_q;
                if (pend_q) begin
                    skid_d     = conv;
                    skid_idx_d = pend_idx_q;
                end
            end else if (pend_q) begin
                dvalid_d = 1'b1;
                dout_d   = conv;
                didx_d   = pend_idx_q;
                dlast_d  = (pend_idx_q == LAST_IDX);
            end else begin
                dvalid_d = 1'b0;
            end
        end else if (pend_q) begin
            // Output stalled: park the arriving beat in the skid slot.
            skid_v_d   = 1'b1;
            skid_d     = conv;
            skid_idx_d = pend_idx_q;
        end
`ifdef SIGNED_VECTOR_ACC_READER_SAT_EN
        sat_d = sat_q | (pend_q & rd_clamp);
`endif
    end

    // Buffer storage: no reset, contents are qualified by the full flags.
    always_ff @(posedge clk_i) begin
        if (wr_en) mem_q[{wbank_q, widx_q}] <= din_i;
        if (rd_en) rdata_q <= mem_q[{ibank_q, ridx_q}];
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            widx_q     <= '0;
            wbank_q    <= 1'b0;
            wr_act_q   <= 1'b0;
            full_q     <= '0;
            overflow_q <= 1'b0;
            drop_cnt_q <= '0;
            ibank_q    <= 1'b0;
            ridx_q     <= '0;
            rbank_q    <= 1'b0;
            pend_q     <= 1'b0;
            pend_idx_q <= '0;
            skid_v_q   <= 1'b0;
            skid_q     <= '0;
            skid_idx_q <= '0;
            dvalid_q   <= 1'b0;
            dout_q     <= '0;
            didx_q     <= '0;
            dlast_q    <= 1'b0;
`ifdef SIGNED_VECTOR_ACC_READER_SAT_EN
            sat_q      <= 1'b0;
`endif
        end else begin
            widx_q     <= widx_d;
            wbank_q    <= wbank_d;
            wr_act_q   <= wr_act_d;
            full_q     <= full_d;
            overflow_q <= overflow_d;
            drop_cnt_q <= drop_cnt_d;
            ibank_q    <= ibank_d;
            ridx_q     <= ridx_d;
            rbank_q    <= rbank_d;
            pend_q     <= pend_d;
            pend_idx_q <= pend_idx_d;
            skid_v_q   <= skid_v_d;
            skid_q     <= skid_d;
            skid_idx_q <= skid_idx_d;
            dvalid_q   <= dvalid_d;
            dout_q     <= dout_d;
            didx_q     <= didx_d;
            dlast_q    <= dlast_d;
`ifdef SIGNED_VECTOR_ACC_READER_SAT_EN
            sat_q      <= sat_d;
`endif
        end
    end

    assign dout_o       = dout_q;
    assign dout_index_o = didx_q;
    assign dout_last_o  = dlast_q;
    assign dout_valid_o = dvalid_q;
    assign overflow_o   = overflow_q;
    assign drop_count_o = drop_cnt_q;
`ifdef SIGNED_VECTOR_ACC_READER_SAT_EN
    assign sat_flag_o   = sat_q;
`endif

endmodule
